// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Controller states and EX operand forwarding select encodings.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_sel_gen.sv
// Per-operand producer match and forwarding priority.
// EX-stage producer beats MEM-stage producer.
module fwd_sel_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrt,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrt,
  output logic              ex_hit,
  output logic [1:0]        sel
);

  logic live;
  logic mem_hit;

  assign live = used &&
    ((ZERO_REG == 0) || (src != '0));

  assign ex_hit  = live && ex_regwrt &&
                   (src == ex_rd);
  assign mem_hit = live && mem_regwrt &&
                   (src == mem_rd);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_EXMEM;
    else if (mem_hit)
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and freeze controller for the 5-stage pipeline.
// Owns the HLT shutdown, memory-wait timeout and perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_hlt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrt,
  input  logic              mem_req,
  input  logic              dmem_ready,
  input  logic              wb_hlt,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              pc_sel_branch,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              mem_wb_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              hlt,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WW =
    (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state_q;
  state_t        state_d;
  logic [WW-1:0] wait_q;
  logic [WW-1:0] wait_d;

  logic [1:0] a_sel;
  logic [1:0] b_sel;
  logic       a_ex_hit;
  logic       b_ex_hit;
  logic       halted;
  logic       freeze;
  logic       load_use;
  logic       do_branch;
  logic       do_stall;
  logic       timeout;

  fwd_sel_gen #(
    .REG_AW   (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_fwd_a (
    .src        (id_rs),
    .used       (id_rs_used),
    .ex_rd      (ex_rd),
    .ex_regwrt  (ex_regwrt),
    .mem_rd     (mem_rd),
    .mem_regwrt (mem_regwrt),
    .ex_hit     (a_ex_hit),
    .sel        (a_sel)
  );

  fwd_sel_gen #(
    .REG_AW   (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_fwd_b (
    .src        (id_rt),
    .used       (id_rt_used),
    .ex_rd      (ex_rd),
    .ex_regwrt  (ex_regwrt),
    .mem_rd     (mem_rd),
    .mem_regwrt (mem_regwrt),
    .ex_hit     (b_ex_hit),
    .sel        (b_sel)
  );

  assign halted   = (state_q == HALTED);
  assign freeze   = mem_req && !dmem_ready
                    && !halted;
  assign load_use = ex_memread &&
                    (a_ex_hit || b_ex_hit);

  assign do_branch = rst_n && !halted &&
                     !freeze && branch_taken;
  assign do_stall  = rst_n && !halted &&
                     !freeze && !branch_taken &&
                     load_use;

  assign timeout = (state_q == MEM_WAIT) &&
                   freeze &&
                   (wait_q == WAIT_LAST);

  // Freeze and halt mask everything; branch beats load-use beats HLT.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (halted || freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
    end else if (id_hlt) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (!freeze)
          state_d = RUN;
        else if (timeout)
          state_d = HALTED;
        else
          wait_d = wait_q + 1'b1;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (wb_hlt)
      state_d = HALTED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      fwd_a_sel   <= FWD_RF;
      fwd_b_sel   <= FWD_RF;
      hlt         <= 1'b0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (id_ex_write) begin
        fwd_a_sel <= id_ex_bubble ? FWD_RF : a_sel;
        fwd_b_sel <= id_ex_bubble ? FWD_RF : b_sel;
      end
      if (state_d == HALTED)
        hlt <= 1'b1;
      if (timeout)
        mem_timeout <= 1'b1;
      if (do_stall && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (do_branch && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Random-stimulus bench for pipe_hazard_ctrl against a behavioural model.
// Small counters expose saturation; long waits provoke the timeout.
module tb_pipe_hazard_ctrl;

  localparam int AW   = 4;
  localparam int WMAX = 15;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic          id_rs_used, id_rt_used, id_hlt;
  logic          ex_regwrt, ex_memread;
  logic          mem_regwrt, mem_req, dmem_ready;
  logic          wb_hlt, branch_taken;
  logic          pc_write, pc_sel_branch;
  logic          if_id_write, id_ex_write;
  logic          ex_mem_write, if_id_flush;
  logic          id_ex_bubble, mem_wb_bubble;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          hlt, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW   (AW),
    .ZERO_REG (1),
    .WAIT_MAX (WMAX),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_used    (id_rs_used),
    .id_rt_used    (id_rt_used),
    .id_hlt        (id_hlt),
    .ex_rd         (ex_rd),
    .ex_regwrt     (ex_regwrt),
    .ex_memread    (ex_memread),
    .mem_rd        (mem_rd),
    .mem_regwrt    (mem_regwrt),
    .mem_req       (mem_req),
    .dmem_ready    (dmem_ready),
    .wb_hlt        (wb_hlt),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .pc_sel_branch (pc_sel_branch),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_mem_write  (ex_mem_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .mem_wb_bubble (mem_wb_bubble),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .hlt           (hlt),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit hit(
    input logic [AW-1:0] s, input bit u,
    input logic [AW-1:0] d, input bit w);
    return u && w && s == d && s != 0;
  endfunction

  function automatic int pick(
    input logic [AW-1:0] s, input bit u);
    if (hit(s, u, ex_rd, ex_regwrt)) return 1;
    if (hit(s, u, mem_rd, mem_regwrt)) return 2;
    return 0;
  endfunction

  // model state
  bit m_halted, m_to;
  int m_fa, m_fb, m_stall, m_flush, m_nr;

  initial begin
    int wait_left;
    bit frz, lu;
    logic [7:0] ctl, exp_ctl;
    wait_left = 0;
    m_halted = 0; m_to = 0; m_nr = 0;
    m_fa = 0; m_fb = 0;
    m_stall = 0; m_flush = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("fwd_a", 32'(fwd_a_sel), m_fa);
        check("fwd_b", 32'(fwd_b_sel), m_fb);
        check("hlt", 32'(hlt), 32'(m_halted));
        check("timeout", 32'(mem_timeout),
              32'(m_to));
        check("stall_cnt", 32'(stall_cnt),
              m_stall);
        check("flush_cnt", 32'(flush_cnt),
              m_flush);
      end
      rst_n = !(i < 2 ||
        $urandom_range(0, m_halted ? 7 : 150) == 0);
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3));
      mem_rd = AW'($urandom_range(0, 3));
      id_rs_used = $urandom_range(0, 3) != 0;
      id_rt_used = $urandom_range(0, 3) != 0;
      ex_regwrt  = $urandom_range(0, 3) != 0;
      mem_regwrt = $urandom_range(0, 3) != 0;
      ex_memread = $urandom_range(0, 2) == 0;
      id_hlt = $urandom_range(0, 15) == 0;
      wb_hlt = $urandom_range(0, 120) == 0;
      branch_taken = $urandom_range(0, 5) == 0;
      if (wait_left == 0 &&
          $urandom_range(0, 25) == 0)
        wait_left = $urandom_range(3, 20);
      if (wait_left > 0) begin
        mem_req = 1'b1;
        dmem_ready = 1'b0;
        wait_left--;
      end else begin
        mem_req = $urandom_range(0, 1) != 0;
        dmem_ready = $urandom_range(0, 1) != 0;
      end
      #1;
      frz = rst_n && !m_halted &&
            mem_req && !dmem_ready;
      lu = ex_memread &&
        (hit(id_rs, id_rs_used, ex_rd, ex_regwrt)
      || hit(id_rt, id_rt_used, ex_rd, ex_regwrt));
      // {pc_w, pc_sel, ifid_w, idex_w, exmem_w,
      //  ifid_flush, idex_bub, memwb_bub}
      if (!rst_n)
        exp_ctl = 8'b0000_0111;
      else if (m_halted || frz)
        exp_ctl = 8'b0000_0001;
      else if (branch_taken)
        exp_ctl = 8'b1111_1110;
      else if (lu)
        exp_ctl = 8'b0001_1010;
      else if (id_hlt)
        exp_ctl = 8'b0001_1000;
      else
        exp_ctl = 8'b1011_1000;
      ctl = {pc_write, pc_sel_branch,
             if_id_write, id_ex_write,
             ex_mem_write, if_id_flush,
             id_ex_bubble, mem_wb_bubble};
      check("ctl", 32'(ctl), 32'(exp_ctl));
      if (!rst_n) begin
        m_halted = 0; m_to = 0; m_nr = 0;
        m_fa = 0; m_fb = 0;
        m_stall = 0; m_flush = 0;
      end else begin
        if (exp_ctl[4]) begin
          m_fa = exp_ctl[1] ? 0 :
                 pick(id_rs, id_rs_used);
          m_fb = exp_ctl[1] ? 0 :
                 pick(id_rt, id_rt_used);
        end
        if (!m_halted && !frz) begin
          if (branch_taken) begin
            if (m_flush < CMAX) m_flush++;
          end else if (lu) begin
            if (m_stall < CMAX) m_stall++;
          end
        end
        m_nr = frz ? m_nr + 1 : 0;
        if (frz && m_nr == WMAX + 1) begin
          m_to = 1;
          m_halted = 1;
        end
        if (wb_hlt) m_halted = 1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
